// File: rtl/tracer_pkg.sv
// Shared tracer definitions: injector state encoding and config-bus register map.
package tracer_pkg;

  localparam logic [1:0] INJ_IDLE    = 2'd0;
  localparam logic [1:0] INJ_DRIVE   = 2'd1;
  localparam logic [1:0] INJ_HOLDOFF = 2'd2;

  localparam logic [15:0] CFG_ADDR_PATCH_INJ = 16'h0010;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/config_reg16.sv
// Config-bus register slice: loads the write data when the strobe hits its address.
module config_reg16 #(
  parameter logic [15:0] ADDR      = 16'h0000,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_config_addr,
  input  logic [15:0] i_config_data,
  input  logic        i_config_strobe,
  output logic [15:0] o_q
);

  logic [15:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_config_strobe && (i_config_addr == ADDR)) begin
      r_q <= i_config_data;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/patch_injector.sv
// Replaces RAM read-burst data with patch-store words while a matching burst is active.
// Handshake: a word is consumed whenever burst_word_strobe is high while driving; patch_data_next echoes it in the same cycle.
module patch_injector
  import tracer_pkg::*;
#(
  parameter logic [15:0] CONFIG_ADDR = CFG_ADDR_PATCH_INJ,
  parameter int          MAX_WORDS   = 64
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [15:0] config_addr,
  input  logic [15:0] config_data,
  input  logic        config_strobe,
  input  logic        burst_is_read,
  input  logic        burst_word_strobe,
  input  logic        burst_end,
  input  logic        patch_trigger,
  input  logic [15:0] patch_data,
  output logic        patch_data_next,
  output logic        ram_dq_oe,
  output logic [15:0] ram_dq_out,
  output logic        inject_active,
  output logic [15:0] inject_count,
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] LP_LAST_WORD = 8'(MAX_WORDS - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_word_cnt;
  logic [15:0] r_inject_count;

  logic [15:0] w_cfg_q;
  logic        w_enable;
  logic        w_unused_cfg;
  logic        w_trig_ok;
  logic        w_driving;
  logic [1:0]  w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_start;

  config_reg16 #(
    .ADDR      (CONFIG_ADDR),
    .RESET_VAL (16'h0000)
  ) u_ctrl_reg (
    .i_clk           (mclk),
    .i_rst_n         (reset),
    .i_config_addr   (config_addr),
    .i_config_data   (config_data),
    .i_config_strobe (config_strobe),
    .o_q             (w_cfg_q)
  );

  assign w_enable     = w_cfg_q[0];
  assign w_unused_cfg = ^w_cfg_q[15:1];
  assign w_trig_ok    = patch_trigger && burst_is_read && w_enable;
  assign w_driving    = (r_state == INJ_DRIVE);

  // burst_end outranks the word limit; a trigger landing with burst_end restarts immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_word_cnt;
    w_start     = 1'b0;
    case (r_state)
      INJ_IDLE: begin
        if (w_trig_ok) begin
          w_state_nxt = INJ_DRIVE;
          w_cnt_nxt   = 8'd0;
          w_start     = 1'b1;
        end
      end
      INJ_DRIVE: begin
        if (burst_end) begin
          if (w_trig_ok) begin
            w_state_nxt = INJ_DRIVE;
            w_cnt_nxt   = 8'd0;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = INJ_IDLE;
          end
        end else if (burst_word_strobe) begin
          w_cnt_nxt = r_word_cnt + 8'd1;
          if (r_word_cnt == LP_LAST_WORD) begin
            w_state_nxt = INJ_HOLDOFF;
          end
        end
      end
      INJ_HOLDOFF: begin
        if (burst_end) begin
          if (w_trig_ok) begin
            w_state_nxt = INJ_DRIVE;
            w_cnt_nxt   = 8'd0;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = INJ_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = INJ_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!reset) begin
      r_state        <= INJ_IDLE;
      r_word_cnt     <= 8'd0;
      r_inject_count <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_cnt_nxt;
      if (w_start) begin
        r_inject_count <= sat_inc16(r_inject_count);
      end
    end
  end

  // The advance pulse is held off during reset so the store never steps on a dying burst.
  assign patch_data_next = w_driving && burst_word_strobe && reset;
  assign ram_dq_oe       = w_driving;
  assign ram_dq_out      = w_driving ? patch_data : 16'h0000;
  assign inject_active   = (r_state != INJ_IDLE);
  assign inject_count    = r_inject_count;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_patch_injector.sv
// Directed bench for patch_injector with a small patch-store model feeding patch_data.
module tb_patch_injector;
  import tracer_pkg::*;

  logic        mclk = 1'b0;
  logic        reset;
  logic [15:0] config_addr;
  logic [15:0] config_data;
  logic        config_strobe;
  logic        burst_is_read;
  logic        burst_word_strobe;
  logic        burst_end;
  logic        patch_trigger;
  logic [15:0] patch_data;
  logic        patch_data_next;
  logic        ram_dq_oe;
  logic [15:0] ram_dq_out;
  logic        inject_active;
  logic [15:0] inject_count;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  patch_injector #(
    .CONFIG_ADDR (16'h0010),
    .MAX_WORDS   (4)
  ) dut (
    .mclk              (mclk),
    .reset             (reset),
    .config_addr       (config_addr),
    .config_data       (config_data),
    .config_strobe     (config_strobe),
    .burst_is_read     (burst_is_read),
    .burst_word_strobe (burst_word_strobe),
    .burst_end         (burst_end),
    .patch_trigger     (patch_trigger),
    .patch_data        (patch_data),
    .patch_data_next   (patch_data_next),
    .ram_dq_oe         (ram_dq_oe),
    .ram_dq_out        (ram_dq_out),
    .inject_active     (inject_active),
    .inject_count      (inject_count),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  always #5 mclk = ~mclk;

  // patch store model: reloads F000 on a trigger, advances on each next pulse
  always @(posedge mclk) begin
    if (patch_trigger) patch_data <= 16'hF000;
    else if (patch_data_next) patch_data <= patch_data + 16'd1;
  end

  task automatic tick();
    @(posedge mclk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [15:0] addr, input logic [15:0] data);
    config_addr   = addr;
    config_data   = data;
    config_strobe = 1'b1;
    tick();
    config_strobe = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] exp_cnt);
    chk({tag, "_oe"},    32'(ram_dq_oe), 32'd0);
    chk({tag, "_dq"},    32'(ram_dq_out), 32'd0);
    chk({tag, "_act"},   32'(inject_active), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(INJ_IDLE));
    chk({tag, "_cnt"},   32'(inject_count), 32'(exp_cnt));
  endtask

  initial begin
    patch_data        = 16'h0000;
    reset             = 1'b0;
    config_addr       = 16'h0000;
    config_data       = 16'h0000;
    config_strobe     = 1'b0;
    burst_is_read     = 1'b0;
    burst_word_strobe = 1'b0;
    burst_end         = 1'b0;
    patch_trigger     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk_idle("reset", 16'd0);
    chk("reset_next", 32'(patch_data_next), 32'd0);

    // enable still 0: read trigger ignored
    patch_trigger = 1'b1; burst_is_read = 1'b1;
    tick();
    patch_trigger = 1'b0;
    chk_idle("dis_trig", 16'd0);

    cfg_write(16'h0010, 16'h0001);
    // write burst ignored
    patch_trigger = 1'b1; burst_is_read = 1'b0;
    tick();
    patch_trigger = 1'b0;
    chk_idle("wr_trig", 16'd0);

    // basic read burst; 4th strobe coincides with burst_end
    patch_trigger = 1'b1; burst_is_read = 1'b1;
    #1 chk("t1_pre_oe", 32'(ram_dq_oe), 32'd0);
    tick();
    patch_trigger = 1'b0;
    chk("t1_oe", 32'(ram_dq_oe), 32'd1);
    chk("t1_act", 32'(inject_active), 32'd1);
    chk("t1_next_idle", 32'(patch_data_next), 32'd0);
    for (int i = 0; i < 3; i++) begin
      burst_word_strobe = 1'b1;
      #1;
      chk("t1_next", 32'(patch_data_next), 32'd1);
      chk("t1_dq", 32'(ram_dq_out), 32'hF000 + 32'(i));
      tick();
      burst_word_strobe = 1'b0;
    end
    burst_word_strobe = 1'b1; burst_end = 1'b1;
    #1;
    chk("t1_next_end", 32'(patch_data_next), 32'd1);
    chk("t1_dq_end", 32'(ram_dq_out), 32'hF003);
    tick();
    burst_word_strobe = 1'b0; burst_end = 1'b0;
    chk_idle("t1_done", 16'd1);

    // word limit: 6 strobes, only 4 driven
    patch_trigger = 1'b1;
    tick();
    patch_trigger = 1'b0;
    for (int i = 0; i < 6; i++) begin
      burst_word_strobe = 1'b1;
      #1;
      if (i < 4) begin
        chk("t3_next", 32'(patch_data_next), 32'd1);
        chk("t3_dq", 32'(ram_dq_out), 32'hF000 + 32'(i));
      end else begin
        chk("t3_next_hold", 32'(patch_data_next), 32'd0);
        chk("t3_oe_hold", 32'(ram_dq_oe), 32'd0);
        chk("t3_dq_hold", 32'(ram_dq_out), 32'd0);
        chk("t3_state_hold", 32'(dbg_state), 32'(INJ_HOLDOFF));
      end
      tick();
      burst_word_strobe = 1'b0;
    end
    patch_trigger = 1'b1;
    tick();
    patch_trigger = 1'b0;
    chk("t3_hold_trig_state", 32'(dbg_state), 32'(INJ_HOLDOFF));
    chk("t3_hold_trig_cnt", 32'(inject_count), 32'd2);
    chk("t3_hold_act", 32'(inject_active), 32'd1);
    burst_end = 1'b1;
    tick();
    burst_end = 1'b0;
    chk_idle("t3_done", 16'd2);

    // restart on burst_end + trigger
    patch_trigger = 1'b1;
    tick();
    patch_trigger = 1'b0;
    for (int i = 0; i < 2; i++) begin
      burst_word_strobe = 1'b1;
      tick();
      burst_word_strobe = 1'b0;
    end
    patch_trigger = 1'b1;
    tick();
    patch_trigger = 1'b0;
    chk("t4_drive_trig_cnt", 32'(inject_count), 32'd3);
    chk("t4_drive_trig_state", 32'(dbg_state), 32'(INJ_DRIVE));
    patch_trigger = 1'b1; burst_end = 1'b1;
    tick();
    patch_trigger = 1'b0; burst_end = 1'b0;
    chk("t4_restart_oe", 32'(ram_dq_oe), 32'd1);
    chk("t4_restart_cnt", 32'(inject_count), 32'd4);
    chk("t4_restart_dq", 32'(ram_dq_out), 32'hF000);
    for (int i = 0; i < 3; i++) begin
      burst_word_strobe = 1'b1;
      tick();
      burst_word_strobe = 1'b0;
      chk("t4_still_drive", 32'(dbg_state), 32'(INJ_DRIVE));
    end
    burst_word_strobe = 1'b1;
    tick();
    burst_word_strobe = 1'b0;
    chk("t4_limit", 32'(dbg_state), 32'(INJ_HOLDOFF));
    burst_end = 1'b1;
    tick();
    burst_end = 1'b0;
    chk_idle("t4_done", 16'd4);

    // enable cleared mid-burst keeps driving; then reset mid-DRIVE
    patch_trigger = 1'b1;
    tick();
    patch_trigger = 1'b0;
    cfg_write(16'h0010, 16'h0000);
    chk("t5_dis_state", 32'(dbg_state), 32'(INJ_DRIVE));
    chk("t5_dis_oe", 32'(ram_dq_oe), 32'd1);
    chk("t5_cnt", 32'(inject_count), 32'd5);
    cfg_write(16'h0010, 16'h0001);
    reset = 1'b0; burst_word_strobe = 1'b1;
    #1 chk("t5_rst_next", 32'(patch_data_next), 32'd0);
    tick();
    reset = 1'b1; burst_word_strobe = 1'b0;
    chk_idle("t5_rst", 16'd0);
    patch_trigger = 1'b1;
    tick();
    patch_trigger = 1'b0;
    chk_idle("t5_post_trig", 16'd0);

    // wrong config address leaves enable at 0
    cfg_write(16'h0011, 16'h0001);
    patch_trigger = 1'b1;
    tick();
    patch_trigger = 1'b0;
    chk_idle("t6_badaddr", 16'd0);

    // saturation: trigger+end every cycle injects one burst per edge
    cfg_write(16'h0010, 16'h0001);
    patch_trigger = 1'b1; burst_end = 1'b1;
    repeat (65534) @(posedge mclk);
    #2 chk("t6_cnt_fffe", 32'(inject_count), 32'hFFFE);
    tick();
    chk("t6_cnt_ffff", 32'(inject_count), 32'hFFFF);
    tick();
    tick();
    chk("t6_cnt_sat", 32'(inject_count), 32'hFFFF);
    chk("t6_oe", 32'(ram_dq_oe), 32'd1);
    patch_trigger = 1'b0;
    tick();
    burst_end = 1'b0;
    chk_idle("t6_done", 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/patch_injector.md
Name: patch_injector

Overview:
- Consumer side of the patch-store handshake: watches `patch_trigger` on the RAM burst monitor path, takes over the RAM data bus for the matching read burst, and drives `patch_data` words in place of real RAM data.
- Pulses `patch_data_next` once per word consumed, so the store advances its data pointer.
- Sits between the patch store and the RAM bus output-enable/data mux in the tracer top level, in the `mclk` domain.
- Enable bit and statistics are reached through the existing config-register bus.

Parameters:
- CONFIG_ADDR, 16'h0010, config register address of the control register (bit0 = inject enable).
- MAX_WORDS, 64, maximum words driven per injected burst (legal range 1..255).

Ports:
- mclk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- config_addr  input  16  config bus address.
- config_data  input  16  config bus write data.
- config_strobe  input  1  config write strobe, one `mclk` cycle.
- burst_is_read  input  1  current burst is a read; valid in the cycle `patch_trigger` is high.
- burst_word_strobe  input  1  one-cycle pulse: RAM samples/presents the next burst word.
- burst_end  input  1  one-cycle pulse: chip-select released, burst finished.
- patch_trigger  input  1  from patch store; address match on the burst address strobe.
- patch_data  input  16  current patch word from patch store.
- patch_data_next  output  1  advance request to patch store.
- ram_dq_oe  output  1  high = tracer drives the RAM DQ bus.
- ram_dq_out  output  16  data driven on DQ while `ram_dq_oe` is high.
- inject_active  output  1  high in DRIVE or HOLDOFF.
- inject_count  output  16  number of bursts injected since reset; saturates at 16'hFFFF.

Behaviour:
- Reset, sampled on the `mclk` edge while `reset` is 0:
  - state = IDLE, enable = 0, word_cnt = 0, `inject_count` = 0, `ram_dq_oe` = 0.
  - `patch_data_next`, `ram_dq_out` and `inject_active` are therefore 0.
  - Reset mid-burst releases the bus on the next edge. No `patch_data_next` pulse is emitted in the reset cycle.
- Control register:
  - `config_strobe` with `config_addr == CONFIG_ADDR` loads enable from `config_data[0]`; all other bits are ignored.
  - Clearing enable during DRIVE does not abort the current burst; it only blocks new triggers.
- States: IDLE, DRIVE, HOLDOFF (2-bit encoding).
- IDLE:
  - `patch_trigger` && `burst_is_read` && enable -> DRIVE, word_cnt = 0, `inject_count` += 1 (saturating). `ram_dq_oe` becomes 1 on the same edge.
  - A trigger on a write burst, or with enable = 0, is ignored.
- DRIVE:
  - `ram_dq_oe` = 1.
  - `ram_dq_out` = `patch_data` combinationally, so the first word after the trigger is the store's reload value (F000).
  - `patch_data_next` = `burst_word_strobe` combinationally, same cycle.
  - Each strobe increments word_cnt.
  - A strobe with word_cnt == MAX_WORDS-1 -> HOLDOFF; exactly MAX_WORDS words are driven.
  - `burst_end` -> IDLE and takes priority over the strobe limit.
  - `burst_end` with a simultaneous strobe still pulses `patch_data_next`.
  - `patch_trigger` in DRIVE without `burst_end` in the same cycle is ignored.
- HOLDOFF:
  - `ram_dq_oe` = 0, `ram_dq_out` = 0, no `patch_data_next`; waits for `burst_end` -> IDLE.
  - `patch_trigger` is ignored.
- Simultaneous `burst_end` and a new valid trigger (DRIVE or HOLDOFF): end the old burst and restart in DRIVE on the same edge, with word_cnt = 0 and `inject_count` incremented.
- `ram_dq_out` = 0 whenever `ram_dq_oe` = 0.
- `inject_active` = (state != IDLE).
- Latency: trigger -> `ram_dq_oe` high is 1 edge; strobe -> `patch_data_next` is 0 cycles.
- word_cnt is 8 bits and never wraps (bounded by MAX_WORDS).

Decomposition:
- Shared package `tracer_pkg`: state encoding constants (INJ_IDLE, INJ_DRIVE, INJ_HOLDOFF) and config register address constants, including CONFIG_ADDR's default value.
- Natural single sub-module: `config_reg16`, a config-bus register slice (address match + load + reset value). It is reused by other config-mapped blocks.

Test Plan:
1. Enable = 1, read-burst trigger, 4 strobes, then `burst_end` -> `ram_dq_oe` rises 1 edge after trigger; `ram_dq_out` sequence F000, F001, F002, F003; 4 `patch_data_next` pulses; `inject_count` = 1.
2. Enable = 0 or write-burst trigger -> `ram_dq_oe` stays 0, no `patch_data_next`, `inject_count` = 0.
3. MAX_WORDS = 4, 6 strobes before `burst_end` -> exactly 4 `next` pulses; `ram_dq_oe` drops after the 4th strobe; HOLDOFF until `burst_end`.
4. `burst_end` and a new trigger in the same cycle during DRIVE -> stays driving, word_cnt restarts, `inject_count` = 2.
5. `reset` = 0 asserted mid-DRIVE -> next edge: `ram_dq_oe` = 0, `inject_count` = 0, enable = 0; a later trigger is ignored until enable is rewritten.
6. Write CONFIG_ADDR+1 with data 1 -> enable unchanged (0); 65536 injected bursts -> `inject_count` holds at FFFF.
